// File: rtl/addsub_pkg.sv
// Shared types and helpers for the segmented pipelined adder/subtractor.
package addsub_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int SEG_DEF   = 8;

  // Number of carry-chain segments, which is also the pipeline depth.
  function automatic int nseg(input int width, input int seg);
    return width / seg;
  endfunction

  // Control part of a stage payload. The width-dependent operand and sum
  // fields are added by the top level, which knows WIDTH.
  typedef struct packed {
    logic sub;    // 1: a-b
    logic carry;  // carry out of the most recently resolved segment
    logic cmsb;   // carry into the MSB of that segment
  } stage_ctl_t;

endpackage

// File: rtl/addsub_segment.sv
// One SEG-bit ripple slice: conditions b for subtract and ripples full adders.
module addsub_segment
  import addsub_pkg::*;
#(
  parameter int SEG = SEG_DEF
) (
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_b,
  input  logic           i_sub,
  input  logic           i_cin,
  output logic [SEG-1:0] o_sum,
  output logic           o_cout,
  output logic           o_cmsb
);

  logic [SEG-1:0] w_bx;
  logic [SEG:0]   w_c;

  // b is inverted for subtract; the +1 arrives as the stage-0 carry-in.
  assign w_bx   = i_b ^ {SEG{i_sub}};
  assign w_c[0] = i_cin;

  for (genvar i = 0; i < SEG; i++) begin : g_fa
    assign o_sum[i]  = i_a[i] ^ w_bx[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & w_bx[i]) | (w_c[i] & (i_a[i] ^ w_bx[i]));
  end

  assign o_cout = w_c[SEG];
  assign o_cmsb = w_c[SEG-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/sub: one register stage per SEG-bit carry
// segment, operands skewed along with the transaction, valid/ready handshake.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEG   = SEG_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSEG = nseg(WIDTH, SEG);

  if (WIDTH % SEG != 0) begin : g_bad_seg
    $error("pipelined_addsub: WIDTH must be a multiple of SEG");
  end

  // Everything a transaction carries between stages. b stays unconditioned;
  // each segment applies the sub inversion to its own slice.
  typedef struct packed {
    stage_ctl_t       ctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
  } payload_t;

  payload_t [NSEG-1:0]           w_in;
  payload_t [NSEG-1:0]           w_nxt;
  payload_t [NSEG-1:0]           r_stg;
  logic     [NSEG-1:0]           r_vld_pipe;
  logic     [NSEG-1:0][SEG-1:0]  w_sum_sl;
  logic     [NSEG-1:0]           w_co;
  logic     [NSEG-1:0]           w_cm;
  logic                          w_adv;

  // The whole pipe moves together; it only stalls when a result is parked.
  assign w_adv    = !r_vld_pipe[NSEG-1] || out_ready;
  assign in_ready = w_adv;

  // Stage inputs: stage 0 from the ports (carry-in = sub), others from the previous register.
  always_comb begin
    w_in              = '0;
    w_in[0].ctl.sub   = sub;
    w_in[0].ctl.carry = sub;
    w_in[0].a         = a;
    w_in[0].b         = b;
    for (int k = 1; k < NSEG; k++) begin
      w_in[k] = r_stg[k-1];
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    addsub_segment #(.SEG(SEG)) u_seg (
      .i_a    (w_in[k].a[k*SEG +: SEG]),
      .i_b    (w_in[k].b[k*SEG +: SEG]),
      .i_sub  (w_in[k].ctl.sub),
      .i_cin  (w_in[k].ctl.carry),
      .o_sum  (w_sum_sl[k]),
      .o_cout (w_co[k]),
      .o_cmsb (w_cm[k])
    );
  end

  // Merge each stage's freshly resolved slice and carries into its payload.
  always_comb begin
    w_nxt = w_in;
    for (int k = 0; k < NSEG; k++) begin
      w_nxt[k].s[k*SEG +: SEG] = w_sum_sl[k];
      w_nxt[k].ctl.carry       = w_co[k];
      w_nxt[k].ctl.cmsb        = w_cm[k];
    end
  end

  // Stage registers and valid shift register; all hold together on a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stg      <= '0;
      r_vld_pipe <= '0;
    end else if (w_adv) begin
      r_stg      <= w_nxt;
      r_vld_pipe <= NSEG'({r_vld_pipe, in_valid});
    end
  end

  // Flags come straight off the last register; zero is gated so an idle or
  // freshly reset pipe does not report a zero result.
  assign out_valid = r_vld_pipe[NSEG-1];
  assign sum       = r_stg[NSEG-1].s;
  assign cout      = r_stg[NSEG-1].ctl.carry ^ r_stg[NSEG-1].ctl.sub;
  assign ovf       = r_stg[NSEG-1].ctl.cmsb ^ r_stg[NSEG-1].ctl.carry;
  assign zero      = r_vld_pipe[NSEG-1] && (r_stg[NSEG-1].s == '0);

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench: drivers push expected results, monitors pop and compare.
module tb_pipelined_addsub;

  localparam int NS0 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk   = 0;
  int n_fail  = 0;
  int n_unexp = 0;
  int stl0    = 0;

  logic        rst_n, s_rst_n;
  logic        in_valid, in_ready, sub, out_valid, out_ready, cout, ovf, zero;
  logic [31:0] a, b, sum;

  pipelined_addsub #(.WIDTH(32), .SEG(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  typedef struct {
    logic [31:0] sum;
    logic        cout, ovf, zero;
    int          acc, stl;
  } exp_t;

  exp_t q0[$];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Ideal model: wide add with explicit inversion, overflow from operand/result signs.
  function automatic exp_t model32(input logic [31:0] x, input logic [31:0] y, input logic s);
    exp_t        e;
    logic [32:0] f;
    logic [31:0] yb;
    yb     = s ? ~y : y;
    f      = {1'b0, x} + {1'b0, yb} + 33'(s);
    e.sum  = f[31:0];
    e.cout = f[32] ^ s;
    e.ovf  = (x[31] == yb[31]) && (f[31] != x[31]);
    e.zero = (f[31:0] == 32'h0);
    e.acc  = 0;
    e.stl  = 0;
    return e;
  endfunction

  // Offer one transaction (called at a negedge); push its expectation on accept.
  task automatic send_exp(input logic [31:0] x, input logic [31:0] y, input logic s,
                          input logic [31:0] es, input logic ec, input logic ev, input logic ez);
    exp_t e;
    bit   ok;
    ok = 0;
    a = x; b = y; sub = s; in_valid = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      if (in_ready) begin
        e.sum = es; e.cout = ec; e.ovf = ev; e.zero = ez;
        e.acc = cyc; e.stl = stl0;
        q0.push_back(e);
        ok = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for 200 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_mdl(input logic [31:0] x, input logic [31:0] y, input logic s);
    exp_t e;
    e = model32(x, y, s);
    send_exp(x, y, s, e.sum, e.cout, e.ovf, e.zero);
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && q0.size() != 0; t++) @(negedge clk);
    check("drain_pending", 64'(q0.size()), 64'd0);
  endtask

  // Monitor for the main instance: result compare, latency, stability under stall.
  initial begin
    logic [34:0] hv, cur;
    bit          held;
    exp_t        e;
    held = 0;
    hv   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 0;
      end else begin
        cur = {cout, ovf, zero, sum};
        if (out_valid && held) check("stable_while_stalled", 64'(cur), 64'(hv));
        if (out_valid && !out_ready) begin
          stl0++;
          check("in_ready_low_on_stall", 64'(in_ready), 64'd0);
        end
        held = out_valid && !out_ready;
        hv   = cur;
        if (out_valid && out_ready) begin
          if (q0.size() == 0) begin
            n_chk++; n_fail++; n_unexp++;
            $display("FAIL unexpected_output: got sum=%h with empty scoreboard", sum);
          end else begin
            e = q0.pop_front();
            check("result", 64'(cur), 64'({e.cout, e.ovf, e.zero, e.sum}));
            check("latency", 64'(cyc - e.acc), 64'(NS0 + stl0 - e.stl));
          end
        end
      end
    end
  end

  // Sweep of other geometries with random operands and random handshakes.
  initial begin
    s_rst_n = 1'b0;
    #23 s_rst_n = 1'b1;
  end

  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int W  = (g == 0) ? 32 : (g == 1) ? 24 : 10;
    localparam int S  = (g == 0) ? 32 : (g == 1) ? 6 : 5;
    localparam int NS = W / S;
    localparam int N  = 1000;

    typedef struct {
      logic [W-1:0] sum;
      logic         cout, ovf, zero;
      int           acc, stl;
    } sexp_t;

    logic         iv, ir, ov, orr, sb, co, of, zr;
    logic [W-1:0] sa, sbb, ss;
    sexp_t        q[$];
    int           stl  = 0;
    bit           done = 0;

    pipelined_addsub #(.WIDTH(W), .SEG(S)) u_dut (
      .clk(clk), .rst_n(s_rst_n), .in_valid(iv), .in_ready(ir),
      .a(sa), .b(sbb), .sub(sb), .out_valid(ov), .out_ready(orr),
      .sum(ss), .cout(co), .ovf(of), .zero(zr)
    );

    function automatic sexp_t smodel(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      sexp_t      e;
      logic [W:0] f;
      logic [W-1:0] yb;
      yb     = s ? ~y : y;
      f      = {1'b0, x} + {1'b0, yb} + (W+1)'(s);
      e.sum  = f[W-1:0];
      e.cout = f[W] ^ s;
      e.ovf  = (x[W-1] == yb[W-1]) && (f[W-1] != x[W-1]);
      e.zero = (f[W-1:0] == '0);
      e.acc  = 0;
      e.stl  = 0;
      return e;
    endfunction

    function automatic logic [W-1:0] rnd_op();
      case ($urandom_range(0, 7))
        0:       return '0;
        1:       return '1;
        2:       return {1'b1, {(W-1){1'b0}}};
        3:       return {1'b0, {(W-1){1'b1}}};
        default: return W'($urandom);
      endcase
    endfunction

    initial begin
      orr = 1'b0;
      forever begin
        @(posedge clk); #1;
        orr = ($urandom_range(0, 3) != 0);
      end
    end

    initial begin
      sexp_t e;
      int    sent;
      bit    acc;
      sent = 0; acc = 0;
      iv = 1'b0; sa = '0; sbb = '0; sb = 1'b0;
      wait (s_rst_n);
      for (int t = 0; t < 20000 && sent < N; t++) begin
        @(negedge clk);
        if (acc) begin iv = 1'b0; acc = 0; end
        if (!iv && $urandom_range(0, 3) != 0) begin
          sa = rnd_op(); sbb = rnd_op(); sb = $urandom_range(0, 1) != 0;
          iv = 1'b1;
        end
        if (iv && ir) begin
          e     = smodel(sa, sbb, sb);
          e.acc = cyc;
          e.stl = stl;
          q.push_back(e);
          sent++;
          acc = 1;
        end
      end
      @(posedge clk); #1;
      iv = 1'b0;
      check($sformatf("sw%0d_sent", g), 64'(sent), 64'(N));
      for (int t = 0; t < 2000 && q.size() != 0; t++) @(negedge clk);
      check($sformatf("sw%0d_drain", g), 64'(q.size()), 64'd0);
      done = 1;
    end

    initial begin
      sexp_t e;
      forever begin
        @(negedge clk);
        if (s_rst_n) begin
          if (ov && !orr) stl++;
          if (ov && orr) begin
            if (q.size() == 0) begin
              n_chk++; n_fail++;
              $display("FAIL sw%0d_unexpected: got sum=%h with empty scoreboard", g, ss);
            end else begin
              e = q.pop_front();
              check($sformatf("sw%0d_result", g), 64'({co, of, zr, ss}),
                    64'({e.cout, e.ovf, e.zero, e.sum}));
              check($sformatf("sw%0d_latency", g), 64'(cyc - e.acc), 64'(NS + stl - e.stl));
            end
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Main directed sequence.
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sub = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({out_valid, cout, ovf, zero, sum}), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Hand-computed vectors: a, b, sub -> sum, cout, ovf, zero.
    send_exp(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    drain();
    send_exp(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    send_exp(32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    send_exp(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    send_exp(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    send_exp(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    send_exp(32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    send_exp(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0);
    drain();

    // Back-to-back stream with out_ready dropped for three cycles.
    fork
      begin
        for (int i = 0; i < 8; i++)
          send_mdl(32'hFFFF_FF00 + 32'(i) * 32'h40, 32'h0000_0180 - 32'(i), i[0]);
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three transactions in flight: nothing may come out afterwards.
    for (int i = 0; i < 3; i++) send_mdl(32'h0000_1000 + 32'(i), 32'h0000_0010, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midflight_reset_outputs", 64'({out_valid, cout, ovf, zero, sum}), 64'd0);
    q0.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("no_stale_after_reset", 64'(n_unexp), 64'd0);
    send_exp(32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
    drain();

    for (int t = 0; t < 30000; t++) begin
      if (g_sw[0].done && g_sw[1].done && g_sw[2].done) break;
      @(negedge clk);
    end
    check("sweeps_done", 64'({g_sw[0].done, g_sw[1].done, g_sw[2].done}), 64'h7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined two's-complement adder/subtractor for the fixed-point CORDIC/FFT datapath. Successor to the fixed-width ripple add/sub cells; width and segment size are generic.
- The carry chain is cut into SEG-bit segments, with one register stage per segment and operand skewing.
- A valid/ready handshake with backpressure lets it sit between CORDIC micro-rotation stages and butterfly units.

Parameters:
- WIDTH, 32, operand/result width in bits. WIDTH % SEG == 0 is required; otherwise elaboration fails via assertion.
- SEG, 8, bits resolved per pipeline stage. NSEG = WIDTH/SEG stages (default 4).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and mode presented
- in_ready  out  1  block accepts a transfer this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  0: a+b, 1: a-b (b inverted, carry-in = 1)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  a+b or a-b, modulo 2^WIDTH
- cout  out  1  add: carry-out; sub: borrow (carry-out XOR sub, so 1 means a<b unsigned)
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB
- zero  out  1  sum == 0

Behaviour:
- Reset (async assert, synchronous release): all stage valid bits 0; out_valid, sum, cout, ovf, zero = 0. Reset mid-operation discards all in-flight results; nothing is emitted after release until new inputs arrive.
- Transfer in on in_valid && in_ready. Transfer out on out_valid && out_ready.
- Advance enable: adv = !out_valid || out_ready. in_ready = adv, combinational from out_ready and the last-stage valid; no path from in_valid.
- When adv = 0, every stage register holds, including data and valid bits.
- Bubbles are not collapsed: the pipeline moves as a whole.
- Stage k (0..NSEG-1):
  - Adds bits [k*SEG +: SEG] of a and (b XOR {WIDTH{sub}}).
  - Carry-in is sub for k = 0, otherwise the registered carry from stage k-1.
  - Upper operand slices, sub, and already-computed lower sum slices travel with the transaction in a skew register.
- Latency: exactly NSEG cycles from accept to out_valid with out_ready held high. Throughput is 1 result/cycle.
- ovf uses the MSB-segment carries of the final stage. zero is computed from the final registered sum, not from the combinational path.
- Simultaneous in and out transfer on a full pipeline is legal and sustains full rate.
- Output data is stable while out_valid && !out_ready.
- Wrap-around: results are modulo 2^WIDTH, and overflow is reported only through ovf/cout.
- NSEG = 1 (SEG = WIDTH) degenerates to a single registered stage with latency 1.

Decomposition:
- Shared package addsub_pkg:
  - function nseg(WIDTH, SEG);
  - typedef for a stage payload struct (valid, sub, carry, a/b remainder, sum slices);
  - constant defaults WIDTH_DEF = 32, SEG_DEF = 8.
- One combinational sub-module, addsub_segment:
  - SEG-bit ripple of the existing full-adder cell with b-conditioning;
  - outputs slice sum, carry-out and carry into MSB.
  - Instantiated NSEG times via generate.

Test Plan:
- Add, defaults, out_ready = 1: a = 0x0000_00FF, b = 0x0000_0001, sub = 0 -> after 4 cycles sum = 0x0000_0100, cout = 0, ovf = 0, zero = 0. Checks the carry crossing a segment boundary.
- Subtract, borrow, zero result:
  - a = 5, b = 7, sub = 1 -> sum = 0xFFFF_FFFE, cout = 1, ovf = 0.
  - a = b = 0x1234_5678, sub = 1 -> sum = 0, zero = 1, cout = 0.
- Overflow:
  - 0x7FFF_FFFF + 1 -> sum = 0x8000_0000, ovf = 1, cout = 0.
  - 0xFFFF_FFFF + 1 -> sum = 0, cout = 1, zero = 1, ovf = 0.
- Backpressure: stream 8 back-to-back transactions and hold out_ready = 0 for cycles 5-7 -> in_ready low while out_valid is held, out data stable, no loss or duplication, in-order results matching the reference model.
- Reset mid-flight: three accepted transactions, then assert rst_n = 0 for 1 cycle -> out_valid = 0 immediately and all outputs 0; no stale result appears after release.
- Parameter sweep: (WIDTH, SEG) = (32, 32), (24, 6), (10, 5) with 1000 random operands and random ready/valid -> latency equals NSEG and all results equal the ideal model.
